// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: vector index width,
// the reserved reset vector and the handshake FSM state type.
package int_pkg;

  localparam int unsigned INT_IDX_W = 6;
  localparam logic [INT_IDX_W-1:0] RESET_VEC_IDX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } int_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// Source-flag / CPU handshake bundle of the interrupt controller.
interface interrupt_controller_if #(
  parameter int unsigned NUM_SRC = 8
);
  import int_pkg::*;

  logic [NUM_SRC-1:0]   INT;
  logic [NUM_SRC-1:0]   IE;
  logic                 GIE;
  logic                 INTACK;
  logic                 REQ;
  logic [INT_IDX_W-1:0] IntAddr;
  logic [NUM_SRC-1:0]   CLR;
  logic                 BUSY;

  modport master (
    output INT, IE, GIE, INTACK,
    input  REQ, IntAddr, CLR, BUSY
  );

  modport slave (
    input  INT, IE, GIE, INTACK,
    output REQ, IntAddr, CLR, BUSY
  );

endinterface

// File: rtl/int_prio_enc.sv
// Combinational highest-set-bit encoder; the highest index wins.
module int_prio_enc
  import int_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   req_vec,
  output logic                 valid,
  output logic [INT_IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req_vec[i]) begin
        valid = 1'b1;
        idx   = INT_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: per-source edge/level capture, enables, NMI bypass,
// priority select and a registered REQ/INTACK handshake with one-cycle CLR.
module interrupt_controller
  import int_pkg::*;
#(
  parameter int unsigned          NUM_SRC    = 8,
  parameter logic [INT_IDX_W-1:0] BASE_INDEX = 6'd32,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK  = '0,
  parameter logic [NUM_SRC-1:0]   NMI_MASK   = '0
) (
  input logic                   MCLK,
  input logic                   reset,
  interrupt_controller_if.slave bus
);

  logic [NUM_SRC-1:0]   r_int_d;
  logic [NUM_SRC-1:0]   r_pend_edge;
  logic [NUM_SRC-1:0]   w_rise;
  logic [NUM_SRC-1:0]   w_pend;
  logic [NUM_SRC-1:0]   w_elig;
  logic                 w_win_valid;
  logic [INT_IDX_W-1:0] w_win_idx;
  logic [INT_IDX_W-1:0] w_ack_idx;

  int_state_e           r_state;
  int_state_e           w_state_nxt;
  logic [INT_IDX_W-1:0] r_int_addr;
  logic [INT_IDX_W-1:0] w_addr_nxt;
  logic [NUM_SRC-1:0]   r_clr;
  logic [NUM_SRC-1:0]   w_clr_nxt;
  logic                 r_req;
  logic                 r_busy;

  assign w_rise = bus.INT & ~r_int_d;
  assign w_pend = (EDGE_MASK & r_pend_edge) | (~EDGE_MASK & bus.INT);
  assign w_elig = w_pend & bus.IE & ({NUM_SRC{bus.GIE}} | NMI_MASK);

  // r_clr is high exactly during ACK, so it clears the edge flag at the end
  // of that cycle; a new rising edge in the same cycle re-sets it.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_int_d     <= '0;
      r_pend_edge <= '0;
    end else begin
      r_int_d     <= bus.INT;
      r_pend_edge <= EDGE_MASK & ((r_pend_edge & ~r_clr) | w_rise);
    end
  end

  int_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req_vec (w_elig),
    .valid   (w_win_valid),
    .idx     (w_win_idx)
  );

  assign w_ack_idx = r_int_addr - BASE_INDEX;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_int_addr;
    w_clr_nxt   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_state_nxt = ST_REQ;
          w_addr_nxt  = BASE_INDEX + w_win_idx;
        end
      end
      ST_REQ: begin
        if (bus.INTACK) begin
          w_state_nxt = ST_ACK;
          w_clr_nxt   = NUM_SRC'(1) << w_ack_idx;
        end else if (w_win_valid) begin
          w_addr_nxt  = BASE_INDEX + w_win_idx;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_int_addr <= '0;
      r_clr      <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_int_addr <= w_addr_nxt;
      r_clr      <= w_clr_nxt;
      r_req      <= (w_state_nxt == ST_REQ);
      r_busy     <= (w_state_nxt == ST_ACK);
    end
  end

  assign bus.REQ     = r_req;
  assign bus.IntAddr = r_int_addr;
  assign bus.CLR     = r_clr;
  assign bus.BUSY    = r_busy;

endmodule
